// File: rtl/data_mem_ctrl.sv
// Single-port data memory controller: one load/store per IDLE -> ACCESS -> RESP round trip.
// Define DMEM_MISALIGN_CHECK_EN to reject misaligned H/HU/W accesses instead of forcing alignment.
module data_mem_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 17,
    parameter int MEM_WORDS  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_func3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int LA_W  = IDX_W + 2;
    localparam int NB    = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state, state_nxt;

    logic                  we_q;
    logic [2:0]            func3_q;
    logic [LA_W-1:0]       addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic                  accept;
    logic [IDX_W-1:0]      idx;
    logic [1:0]            lane;
    logic                  bad_f3, misalign, err;
    logic [NB-1:0]         be;
    logic [DATA_WIDTH-1:0] wlanes, mem_word, load_val;
    logic [7:0]            bsel;
    logic [15:0]           hsel;

    // Address bits above the word index wrap around.
    logic unused_addr;
    assign unused_addr = ^req_addr[ADDR_WIDTH-1:LA_W];

    assign accept = req_valid && req_ready;
    assign idx    = addr_q[LA_W-1:2];
    assign lane   = addr_q[1:0];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are forced quiet while reset is held, even before the FSM register clears.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: req_ready = 1'b1;
                RESP: begin
                    rsp_valid = 1'b1;
                    rsp_rdata = rdata_q;
                    rsp_err   = err_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            func3_q <= req_func3;
            addr_q  <= req_addr[LA_W-1:0];
            wdata_q <= req_wdata;
        end
    end

    always_comb begin
        bad_f3 = (func3_q == 3'b011) || (func3_q[2:1] == 2'b11) || (we_q && func3_q[2]);
`ifdef DMEM_MISALIGN_CHECK_EN
        misalign = ((func3_q[1:0] == 2'b01) && lane[0]) ||
                   ((func3_q[1:0] == 2'b10) && (lane != 2'b00));
`else
        misalign = 1'b0;
`endif
        err    = bad_f3 || misalign;
        be     = '0;
        wlanes = wdata_q;
        case (func3_q[1:0])
            2'b00: begin
                be[lane] = 1'b1;
                wlanes   = {NB{wdata_q[7:0]}};
            end
            2'b01: begin
                be[{lane[1], 1'b0} +: 2] = 2'b11;
                wlanes                   = {(NB/2){wdata_q[15:0]}};
            end
            default: be = '1;
        endcase
    end

    assign mem_word = mem[idx];
    assign bsel     = mem_word[{lane, 3'b000} +: 8];
    assign hsel     = mem_word[{lane[1], 4'b0000} +: 16];

    always_comb begin
        case (func3_q)
            3'b000:  load_val = {{(DATA_WIDTH-8){bsel[7]}}, bsel};
            3'b001:  load_val = {{(DATA_WIDTH-16){hsel[15]}}, hsel};
            3'b100:  load_val = {{(DATA_WIDTH-8){1'b0}}, bsel};
            3'b101:  load_val = {{(DATA_WIDTH-16){1'b0}}, hsel};
            default: load_val = mem_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (state == ACCESS) begin
            err_q   <= err;
            rdata_q <= (we_q || err) ? '0 : load_val;
        end
    end

    // Array is never reset; a reset landing on ACCESS blocks the write.
    always_ff @(posedge clk) begin
        if (!rst && state == ACCESS && we_q && !err) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: scoreboard queue of expected responses, immediate-assert checks.
module tb_data_mem_ctrl;
    localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_func3;
    logic [16:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    int passed = 0;
    int total  = 0;
    logic [32:0] exp_q[$];
    logic [32:0] dropped;
    logic [32:0] held;

    data_mem_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Drive a request, wait (bounded) for acceptance; returns one cycle after the accept edge.
    task automatic send(input logic we, input logic [2:0] f3, input logic [16:0] a,
                        input logic [31:0] wd, input logic [31:0] er, input logic ee);
        int n = 0;
        exp_q.push_back({ee, er});
        req_valid = 1'b1; req_we = we; req_func3 = f3; req_addr = a; req_wdata = wd;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_wait", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("access_quiet", 32'(rsp_valid), 32'd0);
    endtask

    // Response must appear two edges after acceptance; rsp_ready high completes it at once.
    task automatic recv(input string tag);
        logic [32:0] e;
        @(posedge clk); #1;
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 33'h1_DEAD_BEEF;
        chk({tag, "_rdata"}, rsp_rdata, e[31:0]);
        chk({tag, "_err"}, 32'(rsp_err), 32'(e[32]));
        @(posedge clk); #1;
        chk({tag, "_idle"}, 32'(req_ready), 32'd1);
    endtask

    task automatic xact(input string tag, input logic we, input logic [2:0] f3, input logic [16:0] a,
                        input logic [31:0] wd, input logic [31:0] er, input logic ee);
        send(we, f3, a, wd, er, ee);
        recv(tag);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_func3 = '0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err",   32'(rsp_err), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'd1);

        xact("sw",  1, F_W,  17'h010, 32'h876543A1, 32'h0,        0);
        xact("lw",  0, F_W,  17'h010, 32'h0,        32'h876543A1, 0);
        xact("lb",  0, F_B,  17'h010, 32'h0,        32'hFFFFFFA1, 0);
        xact("lbu", 0, F_BU, 17'h013, 32'h0,        32'h00000087, 0);
        xact("lh",  0, F_H,  17'h012, 32'h0,        32'hFFFF8765, 0);
        xact("lhu", 0, F_HU, 17'h012, 32'h0,        32'h00008765, 0);
        xact("sb",  1, F_B,  17'h011, 32'h00000055, 32'h0,        0);
        xact("lw_sb", 0, F_W, 17'h010, 32'h0,       32'h876555A1, 0);
        xact("sw_alias", 1, F_W, 17'h1010, 32'hCAFEF00D, 32'h0,   0);
        xact("lw_alias", 0, F_W, 17'h010, 32'h0,    32'hCAFEF00D, 0);
`ifdef DMEM_MISALIGN_CHECK_EN
        xact("lh_mis", 0, F_H, 17'h011, 32'h0, 32'h0, 1);
        xact("lw_mis", 0, F_W, 17'h012, 32'h0, 32'h0, 1);
`else
        xact("lh_mis", 0, F_H, 17'h011, 32'h0, 32'hFFFFF00D, 0);
        xact("lw_mis", 0, F_W, 17'h012, 32'h0, 32'hCAFEF00D, 0);
`endif
        xact("f3_111", 0, 3'b111, 17'h010, 32'h0, 32'h0, 1);
        xact("f3_011", 0, 3'b011, 17'h010, 32'h0, 32'h0, 1);
        xact("sbu_st", 1, F_BU,  17'h010, 32'hFFFFFFFF, 32'h0, 1);
        xact("sh",     1, F_H,   17'h012, 32'h00001234, 32'h0, 0);
        xact("lw_sh",  0, F_W,   17'h010, 32'h0, 32'h1234F00D, 0);

        // Backpressure: response held 5 cycles while a second request waits.
        rsp_ready = 1'b0;
        send(0, F_W, 17'h010, 32'h0, 32'h1234F00D, 0);
        @(posedge clk); #1;
        held = exp_q.pop_front();
        req_valid = 1'b1; req_we = 1'b0; req_func3 = F_BU; req_addr = 17'h013;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rdata", rsp_rdata, held[31:0]);
            chk("bp_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_done_valid", 32'(rsp_valid), 32'd0);
        chk("bp_done_ready", 32'(req_ready), 32'd1);
        exp_q.push_back({1'b0, 32'h00000012});
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("bp_next_accepted", 32'(req_ready), 32'd0);
        recv("bp_next");

        // Reset while in RESP drops the response.
        rsp_ready = 1'b0;
        send(0, F_W, 17'h010, 32'h0, 32'h1234F00D, 0);
        @(posedge clk); #1;
        chk("rr_valid", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("rr_valid_rst", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        #1;
        chk("rr_dropped", 32'(rsp_valid), 32'd0);
        chk("rr_ready", 32'(req_ready), 32'd1);
        dropped = exp_q.pop_front();

        // Reset while in ACCESS suppresses the write.
        xact("sw_020", 1, F_W, 17'h020, 32'h11111111, 32'h0, 0);
        send(1, F_W, 17'h020, 32'h22222222, 32'h0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("ra_ready_rst", 32'(req_ready), 32'd0);
        chk("ra_valid_rst", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        #1;
        chk("ra_ready", 32'(req_ready), 32'd1);
        dropped = exp_q.pop_front();
        xact("lw_020", 0, F_W, 17'h020, 32'h0, 32'h11111111, 0);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of the data word and all data ports.
REQ-002 Parameter ADDR_WIDTH, default 17, SHALL set the width of the byte address.
REQ-003 Parameter MEM_WORDS, default 1024, a power of two, SHALL set the number of DATA_WIDTH words stored.
REQ-004 clk  in  1  sole clock; all state changes on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 req_valid  in  1  load/store request present.
REQ-007 req_ready  out  1  block can accept a request.
REQ-008 req_we  in  1  1 = store, 0 = load.
REQ-009 req_func3  in  3  access size: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are load-only).
REQ-010 req_addr  in  ADDR_WIDTH  byte address.
REQ-011 req_wdata  in  DATA_WIDTH  store data, taken from the low lanes.
REQ-012 rsp_valid  out  1  response present.
REQ-013 rsp_ready  in  1  requester accepts the response.
REQ-014 rsp_rdata  out  DATA_WIDTH  load result; 0 for stores and errors.
REQ-015 rsp_err  out  1  request rejected; no memory side effect.

Function
REQ-016 The FSM SHALL have three states: IDLE -> ACCESS -> RESP -> IDLE.
REQ-017 req_ready SHALL be 1 only in IDLE; a request is accepted on req_valid && req_ready, and all request fields are captured at acceptance.
REQ-018 IDLE SHALL go to ACCESS on acceptance; ACCESS SHALL last exactly one cycle and perform the write or the word read; RESP SHALL hold until rsp_valid && rsp_ready.
REQ-019 Latency: a request accepted at edge N SHALL make rsp_valid high in cycle N+2; peak throughput is one transaction per 3 cycles.
REQ-020 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL be stable until the handshake; the FSM returns to IDLE on the next cycle.
REQ-021 If rsp_ready is already high when RESP is entered, the response SHALL complete in that first RESP cycle.
REQ-022 Word index = req_addr[log2(MEM_WORDS)+1:2]; higher address bits SHALL be ignored (wrap-around).
REQ-023 Lane select = req_addr[1:0]. SB writes one byte lane, SH two lanes, SW all four; unselected bytes SHALL be preserved.
REQ-024 Loads: LB/LH SHALL sign-extend the selected byte/half; LBU/LHU SHALL zero-extend it; LW returns the whole word.
REQ-025 Stores SHALL still produce a response with rsp_rdata = 0 and rsp_err = 0.
REQ-026 func3 011, 110, 111, or a store with func3 100 or 101, SHALL produce no write, rsp_rdata = 0 and rsp_err = 1.
REQ-027 req_valid while the block is busy SHALL be ignored; the requester must hold it until req_ready.

Reset
REQ-028 While rst is high: FSM -> IDLE, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, req_ready = 0.
REQ-029 req_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-030 Reset in ACCESS SHALL suppress that write; reset in RESP SHALL drop the pending response.
REQ-031 Memory array contents SHALL NOT be cleared by reset.

Configuration
REQ-032 Macro DMEM_MISALIGN_CHECK_EN defined: H/HU with addr[0]=1, or W with addr[1:0]!=00, SHALL give no write, rsp_rdata = 0, rsp_err = 1.
REQ-033 Macro undefined: H/HU SHALL ignore addr[0] and W SHALL ignore addr[1:0] (access forced to alignment); rsp_err SHALL flag only the cases in REQ-026.

Verification
REQ-034 SW 0x876543A1 @0x010, then LW @0x010 -> 0x876543A1, rsp_err 0, rsp_valid 2 cycles after each accept.
REQ-035 From that state: LB @0x010 -> 0xFFFFFFA1; LBU @0x013 -> 0x00000087; LH @0x012 -> 0xFFFF8765; LHU @0x012 -> 0x00008765.
REQ-036 SB wdata 0x00000055 @0x011, then LW @0x010 -> 0x876555A1; SW @(0x010 + 4*MEM_WORDS) aliases to @0x010.
REQ-037 Hold rsp_ready low 5 cycles: rsp_valid and rsp_rdata stable, req_ready 0, a concurrent req_valid is not accepted until after the handshake.
REQ-038 LW @0x012 -> macro defined: rsp_err 1, rdata 0; macro undefined: returns the word at 0x010, rsp_err 0. func3 111 -> rsp_err 1 in both builds.
REQ-039 SW 0x11111111 @0x020, then SW 0x22222222 @0x020 with rst asserted during ACCESS, then LW @0x020 -> 0x11111111.
